palette_lut_mp: RTL and testbench

//  Parametrised multi-read-port colour palette LUT with self-initialisation.
//  - Maps pixel indices to colour words for N_RD independent pixel channels.
//  - Adds a write handshake, a read-valid pipeline, and a hardware init sweep

---
 rtl/palette_lut_mp.sv | 129 ++++++++++++
 tb/tb_palette_lut_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_mp.sv
// Multi-read-port palette LUT; a hardware sweep loads identity/zero after reset or clear_req.
// Reads are fully pipelined with latency 1+OUT_REG; writes are held off (wr_ready=0) during the sweep.
module palette_lut_mp #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 12,
  parameter int N_RD          = 2,
  parameter int OUT_REG       = 1,
  parameter int INIT_IDENTITY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic [ADDR_W-1:0]      wr_add,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   clear_req,
  output logic                   init_busy,
  input  logic [N_RD-1:0]        rd_req,
  input  logic [N_RD*ADDR_W-1:0] rd_add,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAT   = 1 + OUT_REG;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_wa;
  logic [DATA_W-1:0]      mem_wd;
  logic                   wr_fire;
  logic                   flush;
  logic [DATA_W-1:0]      rd_word [N_RD];
  logic [N_RD-1:0]        vld_q [LAT];
  logic [N_RD-1:0]        vld_d [LAT];
  logic [N_RD*DATA_W-1:0] dat_q [LAT];
  logic [N_RD*DATA_W-1:0] dat_d [LAT];

  // Control FSM and the single shared memory write port (sweep or user write).
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_wa     = init_cnt_q;
    mem_wd     = '0;
    wr_fire    = 1'b0;
    flush      = 1'b1;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_wa     = init_cnt_q;
        mem_wd     = (INIT_IDENTITY != 0) ? DATA_W'(init_cnt_q) : '0;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == '1) state_d = ST_READY;
      end
      ST_READY: begin
        wr_fire = wr_req;
        mem_we  = wr_req;
        mem_wa  = wr_add;
        mem_wd  = wr_data;
        flush   = clear_req;
        if (clear_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Write-first bypass: a same-cycle accepted write wins over the stored word.
  always_comb begin
    for (int i = 0; i < N_RD; i++) begin
      if (wr_fire && (wr_add == rd_add[i*ADDR_W +: ADDR_W])) rd_word[i] = wr_data;
      else                                                   rd_word[i] = mem_q[rd_add[i*ADDR_W +: ADDR_W]];
    end
  end

  always_comb begin
    for (int s = 0; s < LAT; s++) begin
      vld_d[s] = '0;
      dat_d[s] = dat_q[s];
    end
    if (!flush) begin
      vld_d[0] = rd_req;
      for (int s = 1; s < LAT; s++) vld_d[s] = vld_q[s-1];
    end
    // Data lanes only advance with a valid so idle channels hold their last word.
    for (int i = 0; i < N_RD; i++) begin
      if (vld_d[0][i]) dat_d[0][i*DATA_W +: DATA_W] = rd_word[i];
      for (int s = 1; s < LAT; s++) begin
        if (vld_d[s][i]) dat_d[s][i*DATA_W +: DATA_W] = dat_q[s-1][i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= '0;
        dat_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= vld_d[s];
        dat_q[s] <= dat_d[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_wa] <= mem_wd;
  end

  // Outputs are forced to their reset values for the whole time rst is high.
  assign init_busy = rst || (state_q == ST_INIT);
  assign wr_ready  = !rst && (state_q == ST_READY);
  assign rd_valid  = rst ? '0 : vld_q[LAT-1];
  assign rd_data   = rst ? '0 : dat_q[LAT-1];

endmodule

// File: tb/tb_palette_lut_mp.sv
// Directed bench for palette_lut_mp: expected reads are queued at issue time and
// checked (data and arrival cycle) by an independent monitor.
module tb_palette_lut_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [7:0]  wr_add;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        clear_req;
  logic        init_busy;
  logic [1:0]  rd_req;
  logic [15:0] rd_add;
  logic [23:0] rd_data;
  logic [1:0]  rd_valid;

  typedef struct {
    logic [11:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   stray  = 0;

  palette_lut_mp dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_add    (wr_add),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clear_req (clear_req),
    .init_busy (init_busy),
    .rd_req    (rd_req),
    .rd_add    (rd_add),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    wr_req    = 1'b0;
    wr_add    = '0;
    wr_data   = '0;
    clear_req = 1'b0;
    rd_req    = '0;
  endtask

  // Result appears LAT=2 cycles after the request is sampled.
  task automatic issue_rd(input int ch, input logic [7:0] addr, input logic [11:0] data);
    exp_t e;
    rd_req[ch]         = 1'b1;
    rd_add[ch*8 +: 8]  = addr;
    e.data = data;
    e.cyc  = cyc + 2;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Counts cycles with init_busy high; optionally drives ignored traffic early on.
  task automatic count_busy(input int noise, input int max_n, output int n);
    n = 0;
    while (init_busy && n < max_n) begin
      idle();
      if (n < noise) begin
        rd_req    = 2'b11;
        rd_add    = {8'(n), 8'(n)};
        wr_req    = 1'b1;
        wr_add    = 8'(n);
        wr_data   = 12'hFFF;
        clear_req = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic mon_ch(input int ch);
    exp_t        e;
    logic [11:0] d;
    int          qs;
    d  = rd_data[ch*12 +: 12];
    qs = (ch == 0) ? q0.size() : q1.size();
    if (rd_valid[ch]) begin
      checks++;
      if (qs == 0) begin
        errors++;
        stray++;
        $display("FAIL stray_valid ch%0d: got valid with data %03h at cycle %0d, expected no valid", ch, d, cyc);
      end else begin
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        if (d !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL rd_ch%0d: got %03h at cycle %0d, expected %03h at cycle %0d", ch, d, cyc, e.data, e.cyc);
        end
      end
    end
    qs = (ch == 0) ? q0.size() : q1.size();
    while (qs > 0 && ((ch == 0) ? q0[0].cyc : q1[0].cyc) < cyc) begin
      if (ch == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid ch%0d: got no valid, expected %03h at cycle %0d", ch, e.data, e.cyc);
      qs = (ch == 0) ? q0.size() : q1.size();
    end
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) mon_ch(ch);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion, expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst    = 1'b1;
    rd_add = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_wr_ready",  32'(wr_ready),  32'd0);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);

    // Test 1: sweep after reset, traffic during the sweep must be ignored
    rst = 1'b0;
    count_busy(50, 2000, n);
    chk("init_len", 32'(n), 32'd256);
    chk("ready_wr_ready",  32'(wr_ready),  32'd1);
    chk("ready_init_busy", 32'(init_busy), 32'd0);
    chk("init_stray", 32'(stray), 32'd0);
    idle(); issue_rd(0, 8'h37, 12'h037); @(negedge clk);
    idle(); repeat (4) @(negedge clk);

    // Test 4: back-to-back sweep read on ch0 while ch1 idles
    for (int i = 0; i < 256; i++) begin
      idle(); issue_rd(0, 8'(i), 12'(i)); @(negedge clk);
    end
    idle(); repeat (4) @(negedge clk);
    chk("sweep_ch1_idle", 32'(stray), 32'd0);

    // Test 2: write then dual-channel read of the same address
    idle(); wr_req = 1'b1; wr_add = 8'h04; wr_data = 12'hABC; @(negedge clk);
    idle(); issue_rd(0, 8'h04, 12'hABC); issue_rd(1, 8'h04, 12'hABC); @(negedge clk);

    // Test 3: write-first collision on ch1, unrelated address on ch0
    idle(); wr_req = 1'b1; wr_add = 8'h33; wr_data = 12'h5A5;
    issue_rd(1, 8'h33, 12'h5A5); issue_rd(0, 8'h34, 12'h034); @(negedge clk);
    idle(); repeat (4) @(negedge clk);

    // Test 5: clear with reads in flight and a simultaneous write
    idle(); rd_req = 2'b11; rd_add = {8'h04, 8'h04}; @(negedge clk);
    idle(); clear_req = 1'b1; wr_req = 1'b1; wr_add = 8'h10; wr_data = 12'h777;
    rd_req = 2'b11; rd_add = {8'h33, 8'h33}; @(negedge clk);
    idle();
    chk("clear_busy",     32'(init_busy), 32'd1);
    chk("clear_wr_ready", 32'(wr_ready),  32'd0);
    count_busy(50, 2000, n);
    chk("clear_len", 32'(n), 32'd256);
    chk("clear_stray", 32'(stray), 32'd0);
    issue_rd(0, 8'h04, 12'h004); issue_rd(1, 8'h10, 12'h010); @(negedge clk);
    idle(); issue_rd(0, 8'h33, 12'h033); @(negedge clk);
    idle(); repeat (4) @(negedge clk);

    // Test 6: reset with reads in flight, then reset again mid-sweep at init_cnt=100
    idle(); rd_req = 2'b11; rd_add = {8'h20, 8'h21}; @(negedge clk);
    idle(); rst = 1'b1; @(negedge clk);
    chk("midrst_rd_valid", 32'(rd_valid),  32'd0);
    chk("midrst_busy",     32'(init_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(50, 100, n);
    chk("partial_len", 32'(n), 32'd100);
    chk("partial_busy", 32'(init_busy), 32'd1);
    rst = 1'b1; @(negedge clk); @(negedge clk);
    rst = 1'b0;
    count_busy(0, 2000, n);
    chk("restart_len", 32'(n), 32'd256);
    chk("restart_stray", 32'(stray), 32'd0);
    issue_rd(0, 8'hAA, 12'h0AA); issue_rd(1, 8'hFF, 12'h0FF); @(negedge clk);
    idle(); repeat (5) @(negedge clk);

    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
